// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Optional build macro used by the top: FIFO_FWFT_EN (first-word-fall-through read).
package fifo_pkg;

  // Snapshot of every status flag the FIFO exposes.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are not reset; the control logic never
// exposes a location before it has been written.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Next array contents: unchanged except the addressed word on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage update on the rising edge.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Build macro FIFO_FWFT_EN: data_out shows the head word combinationally
// (first-word-fall-through); otherwise data_out is registered on each accepted read.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     r_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

  // Reject configurations the pointer/flag arithmetic cannot support.
  if (!is_pow2(DEPTH)) begin : g_chk_pow2
    $error("param_sync_fifo: DEPTH must be a power of two");
  end
  if (DEPTH < 4) begin : g_chk_min_depth
    $error("param_sync_fifo: DEPTH must be at least 4");
  end
  if (!((AE_THRESH > 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_chk_thresh
    $error("param_sync_fifo: thresholds must satisfy 0 < AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q,  count_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;

  logic             rd_acc;
  logic             wr_acc;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;
  fifo_status_t     status;

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  // Flags decode straight from the registered count so they line up with it.
  always_comb begin
    status              = '0;
    status.full         = (count_q == DEPTH_C);
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= AF_C);
    status.almost_empty = (count_q <= AE_C);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // Accept decisions: a read frees a slot, so a write into a full FIFO is
  // accepted when paired with an accepted read.
  always_comb begin
    rd_acc = r_en && !status.empty;
    wr_acc = w_en && (!status.full || rd_acc);
    mem_we = wr_acc && !rst;
  end

  // Next pointers, occupancy and sticky error flags; reset wipes everything
  // and suppresses any error that the ignored requests would have raised.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (rst) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ONE_C;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (clr_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (w_en && !wr_acc) begin
        overflow_d = 1'b1;
      end
      if (r_en && !rd_acc) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem_rdata;
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  // Capture the head word on each accepted read, otherwise hold.
  always_comb begin
    data_out_d = data_out_q;
    if (rst) begin
      data_out_d = '0;
    end else if (rd_acc) begin
      data_out_d = mem_rdata;
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_q;

  // The wrap-bit pointer distance must always equal the tracked occupancy.
  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (rst)
    count_q == (wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo (WIDTH=4, DEPTH=16, AF=14, AE=2).
// Works in both the default build and with FIFO_FWFT_EN defined.
module tb_param_sync_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
`ifdef FIFO_FWFT_EN
  localparam bit IS_FWFT = 1'b1;
`else
  localparam bit IS_FWFT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             w_en;
  logic [WIDTH-1:0] data_in;
  logic             r_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [4:0]       count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  int checks   = 0;
  int failures = 0;

  logic [3:0] model_q[$];

  typedef struct {
    logic       w_en;
    logic [3:0] din;
    logic       r_en;
    logic       clr;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       udf;
    logic [3:0] dout;
    logic       chk_dout;
  } vec_t;

  vec_t vecs[35];

  param_sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then settle 1 time unit past the edge.
  task automatic applyStimulus(input logic w, input logic [3:0] d, input logic r,
                               input logic c, input logic rs);
    w_en    = w;
    data_in = d;
    r_en    = r;
    clr_err = c;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Pop n words with r_en only, comparing against the model queue.
  task automatic drainCheck(input int n, input string tag);
    logic [3:0] exp_w;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      exp_w = model_q.pop_front();
      checkOutput($sformatf("%s_cnt%0d", tag, i), count, model_q.size());
      if (!IS_FWFT) begin
        checkOutput($sformatf("%s_dout%0d", tag, i), data_out, exp_w);
      end else if (model_q.size() > 0) begin
        checkOutput($sformatf("%s_dout%0d", tag, i), data_out, model_q[0]);
      end
    end
    checkOutput({tag, "_empty"}, empty, 1'b1);
  endtask

  initial begin
    logic [3:0] exp_w;
    logic [3:0] exp_d;
    int         c;

    // Test 1/2 table: fill 16, overflow write, read 16, underflow read, clear.
    for (int i = 0; i < 16; i++) begin
      c = i + 1;
      vecs[i] = '{w_en: 1'b1, din: 4'(i), r_en: 1'b0, clr: 1'b0, cnt: 5'(c),
                  full: (c == 16), empty: 1'b0, af: (c >= 14), ae: (c <= 2),
                  ovf: 1'b0, udf: 1'b0, dout: 4'h0, chk_dout: 1'b1};
    end
    vecs[16] = '{w_en: 1'b1, din: 4'h5, r_en: 1'b0, clr: 1'b0, cnt: 5'd16,
                 full: 1'b1, empty: 1'b0, af: 1'b1, ae: 1'b0,
                 ovf: 1'b1, udf: 1'b0, dout: 4'h0, chk_dout: 1'b1};
    for (int k = 0; k < 16; k++) begin
      c = 15 - k;
      vecs[17 + k] = '{w_en: 1'b0, din: 4'h0, r_en: 1'b1, clr: 1'b0, cnt: 5'(c),
                       full: 1'b0, empty: (c == 0), af: (c >= 14), ae: (c <= 2),
                       ovf: 1'b1, udf: 1'b0,
                       dout: IS_FWFT ? 4'(k + 1) : 4'(k),
                       chk_dout: IS_FWFT ? (k != 15) : 1'b1};
    end
    vecs[33] = '{w_en: 1'b0, din: 4'h0, r_en: 1'b1, clr: 1'b0, cnt: 5'd0,
                 full: 1'b0, empty: 1'b1, af: 1'b0, ae: 1'b1,
                 ovf: 1'b1, udf: 1'b1, dout: 4'hF, chk_dout: !IS_FWFT};
    vecs[34] = '{w_en: 1'b0, din: 4'h0, r_en: 1'b0, clr: 1'b1, cnt: 5'd0,
                 full: 1'b0, empty: 1'b1, af: 1'b0, ae: 1'b1,
                 ovf: 1'b0, udf: 1'b0, dout: 4'hF, chk_dout: !IS_FWFT};

    // Reset state.
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_count", count, 5'd0);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_ae", almost_empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_af", almost_full, 1'b0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_udf", underflow, 1'b0);
    if (!IS_FWFT) checkOutput("rst_dout", data_out, 4'h0);

    for (int i = 0; i < 35; i++) begin
      applyStimulus(vecs[i].w_en, vecs[i].din, vecs[i].r_en, vecs[i].clr, 1'b0);
      checkOutput($sformatf("v%0d_count", i), count, vecs[i].cnt);
      checkOutput($sformatf("v%0d_full", i), full, vecs[i].full);
      checkOutput($sformatf("v%0d_empty", i), empty, vecs[i].empty);
      checkOutput($sformatf("v%0d_af", i), almost_full, vecs[i].af);
      checkOutput($sformatf("v%0d_ae", i), almost_empty, vecs[i].ae);
      checkOutput($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
      checkOutput($sformatf("v%0d_udf", i), underflow, vecs[i].udf);
      if (vecs[i].chk_dout) begin
        checkOutput($sformatf("v%0d_dout", i), data_out, vecs[i].dout);
      end
    end

    // Error set wins over clr_err in the same cycle.
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("setwins_udf", underflow, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_udf", underflow, 1'b0);

    // Test 3: hold at 8 with simultaneous read/write, pointers wrap.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
      model_q.push_back(4'(i));
    end
    checkOutput("t3_fill_count", count, 5'd8);
    for (int i = 0; i < 40; i++) begin
      exp_d = 4'((8 + i) & 15);
      applyStimulus(1'b1, exp_d, 1'b1, 1'b0, 1'b0);
      exp_w = model_q.pop_front();
      model_q.push_back(exp_d);
      checkOutput($sformatf("t3_cnt%0d", i), count, 5'd8);
      checkOutput($sformatf("t3_dout%0d", i), data_out, IS_FWFT ? model_q[0] : exp_w);
    end
    drainCheck(8, "t3_drain");
    checkOutput("t3_ovf", overflow, 1'b0);
    checkOutput("t3_udf", underflow, 1'b0);

    // Test 4: full FIFO with simultaneous read and write.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'((i * 3) & 15), 1'b0, 1'b0, 1'b0);
      model_q.push_back(4'((i * 3) & 15));
    end
    checkOutput("t4_full_pre", full, 1'b1);
    applyStimulus(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    exp_w = model_q.pop_front();
    model_q.push_back(4'h9);
    checkOutput("t4_count", count, 5'd16);
    checkOutput("t4_full", full, 1'b1);
    checkOutput("t4_ovf", overflow, 1'b0);
    checkOutput("t4_dout", data_out, IS_FWFT ? model_q[0] : exp_w);
    drainCheck(16, "t4_drain");

    // Test 5: reset mid-operation with w_en high and an error pending.
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_udf_pre", underflow, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'(i + 3), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("t5_count_pre", count, 5'd5);
    applyStimulus(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_count", count, 5'd0);
    checkOutput("t5_empty", empty, 1'b1);
    checkOutput("t5_ovf", overflow, 1'b0);
    checkOutput("t5_udf", underflow, 1'b0);
    if (!IS_FWFT) checkOutput("t5_dout", data_out, 4'h0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_count_post", count, 5'd0);

`ifdef FIFO_FWFT_EN
    // Test 6: first-word-fall-through visibility.
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_empty", empty, 1'b0);
    checkOutput("t6_dout_a", data_out, 4'hA);
    applyStimulus(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_dout_hold", data_out, 4'hA);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_dout_b", data_out, 4'hB);
    checkOutput("t6_count", count, 5'd1);
`endif

    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
